// File: rtl/issue_queue.sv
// issue_queue: age-ordered, collapsing issue queue (slot 0 always holds the oldest entry).
// Optional macro ISSUE_QUEUE_ZERO_REG_EN: physical register 0 is permanently ready.
module issue_queue #(
  parameter int DEPTH      = 8,
  parameter int NUM_WAKEUP = 2,
  parameter int OPCODE_W   = 7,
  parameter int PREG_W     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         kill,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [OPCODE_W-1:0]          disp_opcode,
  input  logic [PREG_W-1:0]            disp_src1,
  input  logic [PREG_W-1:0]            disp_src2,
  input  logic [PREG_W-1:0]            disp_dest,
  input  logic                         disp_src1_rdy,
  input  logic                         disp_src2_rdy,
  input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_W-1:0] wakeup_dest,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [OPCODE_W-1:0]          iss_opcode,
  output logic [PREG_W-1:0]            iss_src1,
  output logic [PREG_W-1:0]            iss_src2,
  output logic [PREG_W-1:0]            iss_dest,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
`ifdef ISSUE_QUEUE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic                valid_r  [DEPTH];
  logic                rdy1_r   [DEPTH];
  logic                rdy2_r   [DEPTH];
  logic [OPCODE_W-1:0] opcode_r [DEPTH];
  logic [PREG_W-1:0]   src1_r   [DEPTH];
  logic [PREG_W-1:0]   src2_r   [DEPTH];
  logic [PREG_W-1:0]   dest_r   [DEPTH];
  logic [CW-1:0]       count_r;

  logic                valid_n  [DEPTH];
  logic                rdy1_n   [DEPTH];
  logic                rdy2_n   [DEPTH];
  logic [OPCODE_W-1:0] opcode_n [DEPTH];
  logic [PREG_W-1:0]   src1_n   [DEPTH];
  logic [PREG_W-1:0]   src2_n   [DEPTH];
  logic [PREG_W-1:0]   dest_n   [DEPTH];
  logic [CW-1:0]       count_n;

  logic          sel_found_s;
  logic [IW-1:0] sel_idx_s;
  logic          disp_fire_s;
  logic          iss_fire_s;
  logic [CW-1:0] wr_idx_s;
  logic          shift_s;
  logic          keep_s;
  logic [IW-1:0] src_idx_s;

  // A register counts as produced when any wakeup port names it; with the
  // zero-register option, register 0 never takes part in wakeup matching.
  function automatic logic wake_hit(input logic [PREG_W-1:0]            src,
                                    input logic [NUM_WAKEUP-1:0]        wv,
                                    input logic [NUM_WAKEUP*PREG_W-1:0] wd);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_WAKEUP; i++) begin
      hit = hit | (wv[i] & (wd[i*PREG_W +: PREG_W] == src));
    end
    return hit & ~(ZERO_REG & (src == {PREG_W{1'b0}}));
  endfunction

  function automatic logic zero_rdy(input logic [PREG_W-1:0] src);
    return ZERO_REG & (src == {PREG_W{1'b0}});
  endfunction

  // Oldest ready entry: scan from the youngest slot so the lowest index wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = {IW{1'b0}};
    for (int j = DEPTH-1; j >= 0; j--) begin
      sel_idx_s   = (valid_r[j] & rdy1_r[j] & rdy2_r[j]) ? IW'(j) : sel_idx_s;
      sel_found_s = sel_found_s | (valid_r[j] & rdy1_r[j] & rdy2_r[j]);
    end
  end

  assign iss_valid   = sel_found_s & ~kill;
  assign iss_opcode  = iss_valid ? opcode_r[sel_idx_s] : {OPCODE_W{1'b0}};
  assign iss_src1    = iss_valid ? src1_r[sel_idx_s]   : {PREG_W{1'b0}};
  assign iss_src2    = iss_valid ? src2_r[sel_idx_s]   : {PREG_W{1'b0}};
  assign iss_dest    = iss_valid ? dest_r[sel_idx_s]   : {PREG_W{1'b0}};
  assign disp_ready  = (count_r != CW'(DEPTH));
  assign count       = count_r;
  assign disp_fire_s = disp_valid & disp_ready & ~kill;
  assign iss_fire_s  = iss_valid & iss_ready;
  assign wr_idx_s    = count_r - CW'(iss_fire_s);

  // Next slot contents: collapse above the issued slot, apply wakeups, append dispatch.
  always_comb begin
    shift_s   = 1'b0;
    keep_s    = 1'b0;
    src_idx_s = {IW{1'b0}};
    count_n   = kill ? {CW{1'b0}} : (count_r + CW'(disp_fire_s) - CW'(iss_fire_s));
    for (int j = 0; j < DEPTH; j++) begin
      valid_n[j]  = 1'b0;
      rdy1_n[j]   = 1'b0;
      rdy2_n[j]   = 1'b0;
      opcode_n[j] = {OPCODE_W{1'b0}};
      src1_n[j]   = {PREG_W{1'b0}};
      src2_n[j]   = {PREG_W{1'b0}};
      dest_n[j]   = {PREG_W{1'b0}};
      shift_s     = iss_fire_s & (IW'(j) >= sel_idx_s);
      src_idx_s   = shift_s ? IW'((j + 1) % DEPTH) : IW'(j);
      keep_s      = valid_r[src_idx_s] & ~(shift_s & (j == DEPTH-1)) & ~kill;
      if (disp_fire_s && (wr_idx_s == CW'(j))) begin
        valid_n[j]  = 1'b1;
        opcode_n[j] = disp_opcode;
        src1_n[j]   = disp_src1;
        src2_n[j]   = disp_src2;
        dest_n[j]   = disp_dest;
        rdy1_n[j]   = disp_src1_rdy | wake_hit(disp_src1, wakeup_valid, wakeup_dest) | zero_rdy(disp_src1);
        rdy2_n[j]   = disp_src2_rdy | wake_hit(disp_src2, wakeup_valid, wakeup_dest) | zero_rdy(disp_src2);
      end else if (keep_s) begin
        valid_n[j]  = 1'b1;
        opcode_n[j] = opcode_r[src_idx_s];
        src1_n[j]   = src1_r[src_idx_s];
        src2_n[j]   = src2_r[src_idx_s];
        dest_n[j]   = dest_r[src_idx_s];
        rdy1_n[j]   = rdy1_r[src_idx_s] | wake_hit(src1_r[src_idx_s], wakeup_valid, wakeup_dest);
        rdy2_n[j]   = rdy2_r[src_idx_s] | wake_hit(src2_r[src_idx_s], wakeup_valid, wakeup_dest);
      end else begin
        valid_n[j]  = 1'b0;
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
      for (int j = 0; j < DEPTH; j++) begin
        valid_r[j]  <= 1'b0;
        rdy1_r[j]   <= 1'b0;
        rdy2_r[j]   <= 1'b0;
        opcode_r[j] <= {OPCODE_W{1'b0}};
        src1_r[j]   <= {PREG_W{1'b0}};
        src2_r[j]   <= {PREG_W{1'b0}};
        dest_r[j]   <= {PREG_W{1'b0}};
      end
    end else begin
      count_r <= count_n;
      for (int j = 0; j < DEPTH; j++) begin
        valid_r[j]  <= valid_n[j];
        rdy1_r[j]   <= rdy1_n[j];
        rdy2_r[j]   <= rdy2_n[j];
        opcode_r[j] <= opcode_n[j];
        src1_r[j]   <= src1_n[j];
        src2_r[j]   <= src2_n[j];
        dest_r[j]   <= dest_n[j];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus random traffic against a queue-based model.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int NW    = 2;
  localparam int OW    = 7;
  localparam int PW    = 5;
`ifdef ISSUE_QUEUE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, kill, disp_valid, disp_ready;
  logic [OW-1:0] disp_opcode, iss_opcode;
  logic [PW-1:0] disp_src1, disp_src2, disp_dest;
  logic          disp_src1_rdy, disp_src2_rdy;
  logic [NW-1:0] wakeup_valid;
  logic [NW*PW-1:0] wakeup_dest;
  logic          iss_valid, iss_ready;
  logic [PW-1:0] iss_src1, iss_src2, iss_dest;
  logic [3:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [OW-1:0] opc;
    logic [PW-1:0] s1, s2, d;
    bit            r1, r2;
  } ent_t;
  ent_t q[$];

  issue_queue #(.DEPTH(DEPTH), .NUM_WAKEUP(NW), .OPCODE_W(OW), .PREG_W(PW)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_dest(disp_dest),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .wakeup_valid(wakeup_valid), .wakeup_dest(wakeup_dest),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dest(iss_dest), .count(count)
  );

  always #5 clk = ~clk;

  function automatic bit whit(input logic [PW-1:0] r);
    bit h = 1'b0;
    if (ZR && r == 5'd0) return 1'b0;
    for (int i = 0; i < NW; i++)
      if (wakeup_valid[i] && wakeup_dest[i*PW +: PW] == r) h = 1'b1;
    return h;
  endfunction

  function automatic int model_sel();
    for (int k = 0; k < q.size(); k++)
      if (q[k].r1 && q[k].r2) return k;
    return -1;
  endfunction

  task automatic idle();
    kill = 1'b0; disp_valid = 1'b0; disp_opcode = 7'd0;
    disp_src1 = 5'd0; disp_src2 = 5'd0; disp_dest = 5'd0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
    wakeup_valid = 2'b00; wakeup_dest = 10'd0; iss_ready = 1'b0;
  endtask

  task automatic disp(input logic [OW-1:0] o, input logic [PW-1:0] a, input logic [PW-1:0] b,
                      input logic [PW-1:0] d, input logic ra, input logic rb);
    disp_valid = 1'b1; disp_opcode = o; disp_src1 = a; disp_src2 = b;
    disp_dest = d; disp_src1_rdy = ra; disp_src2_rdy = rb;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    ent_t nq[$];
    ent_t e;
    int   sel;
    bit   dfire;
    sel   = model_sel();
    dfire = disp_valid && (q.size() != DEPTH) && !kill;
    nq    = q;
    if (kill) nq.delete();
    else begin
      if (sel >= 0 && iss_ready) nq.delete(sel);
      for (int k = 0; k < nq.size(); k++) begin
        nq[k].r1 = nq[k].r1 | whit(nq[k].s1);
        nq[k].r2 = nq[k].r2 | whit(nq[k].s2);
      end
      if (dfire) begin
        e.opc = disp_opcode; e.s1 = disp_src1; e.s2 = disp_src2; e.d = disp_dest;
        e.r1 = disp_src1_rdy | whit(disp_src1) | (ZR && disp_src1 == 5'd0);
        e.r2 = disp_src2_rdy | whit(disp_src2) | (ZR && disp_src2 == 5'd0);
        nq.push_back(e);
      end
    end
    @(posedge clk); #1;
    q = nq;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
    n_checks++;
    if ({iss_opcode, iss_src1, iss_src2, iss_dest} !== 22'd0) begin
      n_fail++; $display("FAIL reset_iss_fields: got %h want 0", {iss_opcode, iss_src1, iss_src2, iss_dest});
    end
    reset = 1'b1; q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    disp(7'h13, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1);
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count1: got %0d want 1", count); end
    n_checks++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL basic_iss_valid: got %b want 1", iss_valid); end
    n_checks++; if (iss_dest !== 5'd5 || iss_opcode !== 7'h13) begin
      n_fail++; $display("FAIL basic_fields: got dest %0d op %h want 5 13", iss_dest, iss_opcode); end
    iss_ready = 1'b1;
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL basic_count0: got %0d want 0", count); end
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid: got %b want 0", iss_valid); end
  endtask

  task automatic test_order();
    disp(7'd1, 5'd7, 5'd8, 5'd10, 1'b0, 1'b1);
    tick();
    disp(7'd2, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1);
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_dest !== 5'd11) begin
      n_fail++; $display("FAIL order_b_first: got valid %b dest %0d want 1 11", iss_valid, iss_dest); end
    iss_ready = 1'b1;
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b0 || count !== 4'd1) begin
      n_fail++; $display("FAIL order_a_waits: got valid %b count %0d want 0 1", iss_valid, count); end
    wakeup_valid = 2'b10; wakeup_dest = {5'd7, 5'd0}; #1;
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL order_no_same_cycle: got %b want 0", iss_valid); end
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_dest !== 5'd10) begin
      n_fail++; $display("FAIL order_a_woken: got valid %b dest %0d want 1 10", iss_valid, iss_dest); end
    iss_ready = 1'b1;
    tick(); idle(); #1;
  endtask

  task automatic test_full_shift();
    for (int k = 0; k < DEPTH; k++) begin
      disp(7'(k), 5'(16 + k), 5'(16 + k), 5'(k), 1'b0, 1'b0);
      tick();
    end
    idle(); #1;
    n_checks++; if (count !== 4'd8 || disp_ready !== 1'b0 || iss_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_state: got count %0d rdy %b iv %b want 8 0 0", count, disp_ready, iss_valid); end
    wakeup_valid = 2'b01; wakeup_dest = {5'd0, 5'd19};
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_dest !== 5'd3) begin
      n_fail++; $display("FAIL full_woken3: got valid %b dest %0d want 1 3", iss_valid, iss_dest); end
    iss_ready = 1'b1; disp(7'd9, 5'd1, 5'd1, 5'd31, 1'b1, 1'b1);
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd7 || disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_issue_no_disp: got count %0d rdy %b want 7 1", count, disp_ready); end
    wakeup_valid = 2'b11; wakeup_dest = {5'd23, 5'd20};
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_dest !== 5'd4) begin
      n_fail++; $display("FAIL full_shift_oldest: got valid %b dest %0d want 1 4", iss_valid, iss_dest); end
    iss_ready = 1'b1;
    tick(); idle(); #1;
    n_checks++; if (iss_dest !== 5'd7 || count !== 4'd6) begin
      n_fail++; $display("FAIL full_shift_next: got dest %0d count %0d want 7 6", iss_dest, count); end
    kill = 1'b1;
    tick(); idle(); #1;
  endtask

  task automatic test_bypass();
    disp(7'd5, 5'd2, 5'd9, 5'd12, 1'b1, 1'b0);
    wakeup_valid = 2'b01; wakeup_dest = {5'd0, 5'd9};
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_dest !== 5'd12) begin
      n_fail++; $display("FAIL bypass_ready: got valid %b dest %0d want 1 12", iss_valid, iss_dest); end
    iss_ready = 1'b1;
    tick(); idle(); #1;
  endtask

  task automatic test_kill();
    for (int k = 0; k < 5; k++) begin
      disp(7'(k), 5'd1, 5'd2, 5'(k), 1'b1, 1'b1);
      tick();
    end
    idle(); #1;
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL kill_setup: got %0d want 5", count); end
    kill = 1'b1; iss_ready = 1'b1; disp(7'd3, 5'd1, 5'd1, 5'd9, 1'b1, 1'b1); #1;
    n_checks++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL kill_iss_valid: got %b want 0", iss_valid); end
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd0 || iss_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill_cleared: got count %0d valid %b want 0 0", count, iss_valid); end
  endtask

  task automatic test_zero_reg();
    disp(7'd6, 5'd0, 5'd5, 5'd13, 1'b0, 1'b1);
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== ZR) begin
      n_fail++; $display("FAIL zero_reg_dispatch: got %b want %b", iss_valid, ZR); end
    wakeup_valid = 2'b01; wakeup_dest = 10'd0;
    tick(); idle(); #1;
    n_checks++; if (iss_valid !== 1'b1 || iss_dest !== 5'd13) begin
      n_fail++; $display("FAIL zero_reg_issuable: got valid %b dest %0d want 1 13", iss_valid, iss_dest); end
    iss_ready = 1'b1;
    tick(); idle(); #1;
  endtask

  task automatic test_random();
    int   sel;
    bit   ev;
    ent_t e;
    for (int c = 0; c < 1500; c++) begin
      kill          = ($urandom_range(0, 99) < 3);
      disp_valid    = ($urandom_range(0, 99) < 65);
      disp_opcode   = 7'($urandom);
      disp_src1     = 5'($urandom_range(0, 7));
      disp_src2     = 5'($urandom_range(0, 7));
      disp_dest     = 5'($urandom);
      disp_src1_rdy = ($urandom_range(0, 99) < 40);
      disp_src2_rdy = ($urandom_range(0, 99) < 40);
      wakeup_valid  = 2'($urandom);
      wakeup_dest   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      iss_ready     = ($urandom_range(0, 99) < 55);
      #1;
      sel = model_sel();
      ev  = (sel >= 0) && !kill;
      e   = '{opc: 7'd0, s1: 5'd0, s2: 5'd0, d: 5'd0, r1: 1'b0, r2: 1'b0};
      if (ev) e = q[sel];
      n_checks++; if (iss_valid !== ev) begin
        n_fail++; $display("FAIL rand_iss_valid c=%0d: got %b want %b", c, iss_valid, ev); end
      n_checks++; if (count !== 4'(q.size())) begin
        n_fail++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, count, q.size()); end
      n_checks++; if (disp_ready !== (q.size() != DEPTH)) begin
        n_fail++; $display("FAIL rand_disp_ready c=%0d: got %b want %b", c, disp_ready, q.size() != DEPTH); end
      n_checks++; if ({iss_opcode, iss_src1, iss_src2, iss_dest} !== {e.opc, e.s1, e.s2, e.d}) begin
        n_fail++; $display("FAIL rand_fields c=%0d: got %h want %h", c,
          {iss_opcode, iss_src1, iss_src2, iss_dest}, {e.opc, e.s1, e.s2, e.d}); end
      tick();
    end
    idle(); #1;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      disp(7'(k), 5'd1, 5'd2, 5'(k), 1'b1, 1'b0);
      tick();
    end
    idle(); #2;
    reset = 1'b0; #1;
    n_checks++; if (count !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: got count %0d iv %b dr %b want 0 0 1", count, iss_valid, disp_ready); end
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_full_shift();
    test_bypass();
    test_kill();
    test_zero_reg();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised, age-ordered issue queue; successor to the single-entry issue slot.
- Holds up to DEPTH micro-ops from dispatch and tracks per-operand readiness via NUM_WAKEUP wakeup ports.
- Issues the oldest fully-ready entry to execute through a valid/ready handshake.
- Collapsing organisation: slot 0 is always the oldest valid entry.

Parameters:
- DEPTH, 8, number of entries (>=2).
- NUM_WAKEUP, 2, number of parallel wakeup ports (>=1).
- OPCODE_W, 7, opcode width.
- PREG_W, 5, physical register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- kill  in  1  synchronous flush of all entries.
- disp_valid  in  1  dispatch micro-op present.
- disp_ready  out  1  queue can accept (not full).
- disp_opcode  in  OPCODE_W  opcode.
- disp_src1  in  PREG_W  source 1 register.
- disp_src2  in  PREG_W  source 2 register.
- disp_dest  in  PREG_W  destination register.
- disp_src1_rdy  in  1  source 1 already available.
- disp_src2_rdy  in  1  source 2 already available.
- wakeup_valid  in  NUM_WAKEUP  per-port wakeup strobe.
- wakeup_dest  in  NUM_WAKEUP*PREG_W  per-port produced register; port i uses bits [i*PREG_W +: PREG_W].
- iss_valid  out  1  oldest ready entry presented.
- iss_ready  in  1  execute accepts.
- iss_opcode  out  OPCODE_W  issued opcode.
- iss_src1  out  PREG_W  issued source 1.
- iss_src2  out  PREG_W  issued source 2.
- iss_dest  out  PREG_W  issued destination.
- count  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Entry state: valid, opcode, src1, src2, dest, rdy1, rdy2. Valid entries are always contiguous in slots 0..count-1.
- Reset (reset=0, asynchronous): all valid, rdy and fields cleared. Outputs: count=0, disp_ready=1, iss_valid=0, all iss_* fields 0.
- disp_ready = (count != DEPTH). Registered-state only; a same-cycle issue does not free a slot for dispatch.
- Dispatch fire = disp_valid & disp_ready & !kill. The entry is written at slot count, or count-1 when an issue fires in the same cycle.
- Wakeup: for each valid entry and each port i with wakeup_valid[i] and wakeup_dest_i == srcN, set rdyN at the edge.
  - Multiple ports may match the same entry; the result is simply OR'd.
  - Wakeup also applies to the entry being dispatched in the same cycle (bypass), so a matching dispatched source is stored ready.
- Select (combinational from registered state): lowest-index valid entry with rdy1 & rdy2.
  - iss_valid = any such entry & !kill.
  - iss_* carry that entry's fields; all zero when iss_valid=0.
- Issue fire = iss_valid & iss_ready. The selected slot k is removed at the edge.
  - Entries k+1..count-1 shift down one slot, carrying any same-cycle wakeup updates.
- Stall (iss_valid=1, iss_ready=0): selection is not sticky. If an older entry becomes ready, the outputs switch to it. Execute must not depend on field stability while stalled.
- A wakeup makes an entry issuable no earlier than the next cycle (ready bits are registered); there is no same-cycle wakeup-to-issue path.
- count next = count + dispatch_fire - issue_fire. It never exceeds DEPTH or drops below 0.
- kill=1: at the next edge all valid and rdy bits clear and count=0. Dispatch and issue in the kill cycle are ignored, and iss_valid is forced 0 combinationally.
- Boundaries:
  - Full (count=DEPTH) with a simultaneous issue: no dispatch accepted that cycle.
  - Empty: iss_valid=0.
  - Reset mid-operation discards all contents immediately.

Optional Feature:
- Macro: ISSUE_QUEUE_ZERO_REG_EN.
- Defined: source address 0 is hard-wired ready. Dispatch with src=0 stores rdy=1 regardless of disp_srcN_rdy, and wakeups with wakeup_dest=0 are ignored.
- Undefined: register 0 is treated like any other register.

Test Plan:
- After reset, dispatch opcode 0x13, src1=3, src2=4, dest=5, both rdy=1 -> next cycle count=1, iss_valid=1, iss_dest=5. With iss_ready=1 -> next cycle count=0, iss_valid=0.
- Dispatch A (src1=7, rdy1=0) then B (both ready) -> B issues first. Then wakeup port 1 with dest=7 -> A's iss_valid rises exactly one cycle after the wakeup.
- Fill 8 entries, none ready -> disp_ready=0, count=8. Wake entry 3 and issue it -> entries 4..7 shift to 3..6, count=7, disp_ready=1.
- Same cycle: dispatch with src2=9 not ready while wakeup port 0 dest=9 -> entry stored with rdy2=1 and issues next cycle.
- Queue holding 5 entries, kill=1 with disp_valid=1 and iss_ready=1 -> iss_valid=0 during kill; next cycle count=0 and nothing was issued or written.
- With ISSUE_QUEUE_ZERO_REG_EN defined: dispatch src1=0, rdy1=0, src2 ready -> issuable the next cycle. Undefined: the entry waits until wakeup dest=0 arrives.
